// File: rtl/fmap_sram_streamer_if.sv
// fmap_sram_streamer_if: job control, write/read streams and SRAM port of
// the feature-map SRAM streamer. The optional 'rep' field exists only when
// FMAP_RD_REPEAT_EN is defined.
interface fmap_sram_streamer_if #(
  parameter int WWORD = 32,
  parameter int WADDR = 5
);
  logic              start;
  logic              mode;
  logic [WADDR-1:0]  base;
  logic [WADDR:0]    len;
`ifdef FMAP_RD_REPEAT_EN
  logic [3:0]        rep;
`endif
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [WWORD-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WWORD-1:0]  out_data;
  logic [WADDR-1:0]  sram_a;
  logic              sram_cen;
  logic              sram_wen;
  logic [WWORD-1:0]  sram_d;
  logic [WWORD-1:0]  sram_q;

  modport slave (
`ifdef FMAP_RD_REPEAT_EN
    input  rep,
`endif
    input  start, mode, base, len, in_valid, in_data, out_ready, sram_q,
    output busy, done, in_ready, out_valid, out_data,
    output sram_a, sram_cen, sram_wen, sram_d
  );

  modport master (
`ifdef FMAP_RD_REPEAT_EN
    output rep,
`endif
    output start, mode, base, len, in_valid, in_data, out_ready, sram_q,
    input  busy, done, in_ready, out_valid, out_data,
    input  sram_a, sram_cen, sram_wen, sram_d
  );
endinterface

// File: rtl/fmap_sram_streamer.sv
// fmap_sram_streamer: moves a job of len words between a stream and a
// single-port SRAM (1-cycle read latency) starting at base, addresses
// wrapping at DEPTH. Reads go through a 2-entry output FIFO.
// Optional feature macro: FMAP_RD_REPEAT_EN adds 'rep' so a read job
// replays the same window rep+1 times back to back.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start; len = 0 completes immediately
// ST_WRITE | in_ready high, one SRAM write per in handshake
// ST_READ  | issuing reads while FIFO + in-flight leaves room
// ST_DRAIN | all reads issued, waiting for FIFO and pipe to empty
module fmap_sram_streamer #(
  parameter int WWORD = 32,
  parameter int WADDR = 5,
  parameter int DEPTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  fmap_sram_streamer_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN} state_t;

  localparam logic [WADDR:0]   L_DEPTH = (WADDR+1)'(DEPTH);
  localparam logic [WADDR:0]   L_ONE   = (WADDR+1)'(1);
  localparam logic [WADDR-1:0] L_LAST  = WADDR'(DEPTH-1);
  localparam logic [WADDR-1:0] L_AONE  = WADDR'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WADDR:0]    r_cnt;
  logic [WADDR:0]    r_len;
  logic [WADDR-1:0]  r_base;
  logic [WADDR-1:0]  r_addr;
  logic              r_inflight;
  logic              r_done;
  logic [WWORD-1:0]  r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
`ifdef FMAP_RD_REPEAT_EN
  logic [3:0]        r_rep;
  logic [3:0]        r_pass;
`endif

  logic [WADDR:0]    w_len_clamp;
  logic [WADDR-1:0]  w_addr_inc;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_more_pass;
  logic              w_wr;
  logic              w_rd;
  logic              w_load;
  logic              w_done_set;

  assign w_len_clamp = (bus.len > L_DEPTH) ? L_DEPTH : bus.len;
  assign w_addr_inc  = (r_addr == L_LAST) ? '0 : r_addr + L_AONE;
  assign w_last      = ((r_cnt + L_ONE) == r_len);
  assign w_pop       = (r_count != 2'd0) & bus.out_ready;
  assign w_push      = r_inflight;
  // Projected FIFO fill if nothing new were issued this cycle.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
`ifdef FMAP_RD_REPEAT_EN
  assign w_more_pass = (r_pass != r_rep);
`else
  assign w_more_pass = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and per-cycle access strobes.
  always_comb begin
    w_next_state = r_state;
    w_wr         = 1'b0;
    w_rd         = 1'b0;
    w_load       = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_len_clamp == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_next_state = bus.mode ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.in_valid) begin
          w_wr = 1'b1;
          if (w_last) begin
            w_next_state = ST_IDLE;
            w_done_set   = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (w_occ < 3'd2) begin
          w_rd = 1'b1;
          if (w_last && !w_more_pass) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_inflight && (r_count == {1'b0, w_pop})) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.in_ready  = (r_state == ST_WRITE);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_fifo[r_rptr];
  assign bus.sram_cen  = ~(w_wr | w_rd);
  assign bus.sram_wen  = ~w_wr;
  assign bus.sram_a    = (w_wr | w_rd) ? r_addr : '0;
  assign bus.sram_d    = w_wr ? bus.in_data : '0;

  // Job bookkeeping: word counter, wrapping address, pass count, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
`ifdef FMAP_RD_REPEAT_EN
      r_rep      <= '0;
      r_pass     <= '0;
`endif
    end else begin
      r_done     <= w_done_set;
      r_inflight <= w_rd;
      if (w_load) begin
        r_cnt  <= '0;
        r_len  <= w_len_clamp;
        r_base <= bus.base;
        r_addr <= bus.base;
`ifdef FMAP_RD_REPEAT_EN
        r_rep  <= bus.rep;
        r_pass <= '0;
`endif
      end else if (w_wr || w_rd) begin
        if (w_last) begin
          // Rewind so a following pass restarts at base with no gap.
          r_cnt  <= '0;
          r_addr <= r_base;
`ifdef FMAP_RD_REPEAT_EN
          if (w_rd) r_pass <= r_pass + 4'd1;
`endif
        end else begin
          r_cnt  <= r_cnt + L_ONE;
          r_addr <= w_addr_inc;
        end
      end
    end
  end

  // Output FIFO: captures sram_q the cycle after each issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= bus.sram_q;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
